// File: rtl/gray_pkg.sv
// Shared constants and the binary-to-Gray encoder for the Gray counter.
// Encoder works at the widest supported width; callers cast to their own width.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH     = 16;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary decode as an XOR prefix chain from the msb down.
// Purely combinational, zero latency, no flow control.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  logic acc;

  always_comb begin
    acc        = g[WIDTH-1];
    b          = '0;
    b[WIDTH-1] = acc;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with Gray-coded load; G, B and TC all registered, one cycle from inputs.
// No backpressure: EN low simply holds the count.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] LD_G,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] B,
  output logic             TC
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] g_q;
  logic             tc_q;
  logic [WIDTH-1:0] ld_bin;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] g_nxt;
  logic             wrap;

  gray2bin #(.WIDTH(WIDTH)) u_ld_dec (
    .g (LD_G),
    .b (ld_bin)
  );

  // Load never flags a wrap; only a real count step across the end does.
  always_comb begin
    cnt_nxt = cnt_q;
    wrap    = 1'b0;
    if (LD) begin
      cnt_nxt = ld_bin;
    end else if (EN) begin
      if (UP) begin
        cnt_nxt = cnt_q + 1'b1;
        wrap    = &cnt_q;
      end else begin
        cnt_nxt = cnt_q - 1'b1;
        wrap    = ~|cnt_q;
      end
    end
    g_nxt = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(cnt_nxt)));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      g_q   <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      g_q   <= g_nxt;
      tc_q  <= wrap;
    end
  end

  assign G  = g_q;
  assign B  = cnt_q;
  assign TC = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4): scoreboard of expected G/B/TC per edge.
module tb_gray_counter;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic         tc;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic         UP = 1'b1;
  logic         LD = 1'b0;
  logic [W-1:0] LD_G = '0;
  logic [W-1:0] G;
  logic [W-1:0] B;
  logic         TC;

  logic         clk_run = 1'b1;
  int           checks = 0;
  int           failures = 0;
  exp_t         sb_q[$];
  logic [W-1:0] m_cnt = '0;

  gray_counter #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .UP   (UP),
    .LD   (LD),
    .LD_G (LD_G),
    .G    (G),
    .B    (B),
    .TC   (TC)
  );

  always #5 CLK = clk_run ? ~CLK : 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference decode: each binary bit is the parity of the Gray bits at or above it.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    logic [W-1:0] r;
    r[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) r[i] = b[i+1] ^ b[i];
    return r;
  endfunction

  // Drive one cycle of inputs, predict the result, then compare after the edge.
  task automatic step(input logic ld, input logic [W-1:0] ldg, input logic en, input logic up,
                      input string tag);
    exp_t         e;
    logic [W-1:0] g_before;
    logic         counted;
    LD = ld; LD_G = ldg; EN = en; UP = up;
    g_before = G;
    counted  = !ld && en;
    e.tc = 1'b0;
    if (ld) m_cnt = ref_g2b(ldg);
    else if (en) begin
      if (up) begin e.tc = (m_cnt == 4'hF); m_cnt = m_cnt + 1'b1; end
      else    begin e.tc = (m_cnt == 4'h0); m_cnt = m_cnt - 1'b1; end
    end
    e.g = ref_b2g(m_cnt);
    e.b = m_cnt;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check({tag, ".G"}, 32'(G), 32'(e.g));
    check({tag, ".B"}, 32'(B), 32'(e.b));
    check({tag, ".TC"}, 32'(TC), 32'(e.tc));
    if (counted) check({tag, ".onebit"}, 32'($countones(G ^ g_before)), 32'd1);
  endtask

  task automatic async_reset(input string tag);
    clk_run = 1'b0;
    #12;
    RST = 1'b1;
    m_cnt = '0;
    sb_q.delete();
    #1;
    check({tag, ".G"}, 32'(G), 32'd0);
    check({tag, ".B"}, 32'(B), 32'd0);
    check({tag, ".TC"}, 32'(TC), 32'd0);
    clk_run = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  logic [W-1:0] up_seq [16];

  initial begin
    up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
               4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    // Power-on reset, then count a little so the mid-count reset is meaningful.
    repeat (2) @(posedge CLK);
    #1;
    check("por.G", 32'(G), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) step(1'b0, '0, 1'b1, 1'b1, "pre");
    async_reset("rst_mid");

    // Full up run with the known Gray sequence.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, "up");
      check("up.seq", 32'(G), 32'(up_seq[i]));
    end

    // Down wrap from zero, then one more step.
    step(1'b0, '0, 1'b1, 1'b0, "dn_wrap");
    check("dn_wrap.Bconst", 32'(B), 32'hF);
    check("dn_wrap.TCconst", 32'(TC), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, "dn_next");
    check("dn_next.Gconst", 32'(G), 32'b1001);

    // Load then count up.
    step(1'b1, 4'b1101, 1'b0, 1'b0, "ld");
    check("ld.Bconst", 32'(B), 32'b1001);
    step(1'b0, '0, 1'b1, 1'b1, "ld_up");
    check("ld_up.Gconst", 32'(G), 32'b1111);

    // Load beats enable, then hold, then direction toggling across the wrap.
    step(1'b1, 4'b1000, 1'b1, 1'b1, "ld_pri");
    check("ld_pri.Bconst", 32'(B), 32'hF);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0011, 1'b0, i[0], "hold");
    check("hold.Gconst", 32'(G), 32'b1000);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1, ~i[0], "toggle");
      check("toggle.Gconst", 32'(G), i[0] ? 32'b1000 : 32'b0000);
    end

    // Loads to the extremes must not pulse TC.
    step(1'b1, 4'b1000, 1'b0, 1'b0, "ld_max");
    step(1'b1, 4'b0000, 1'b1, 1'b1, "ld_zero");
    step(1'b1, 4'b1000, 1'b1, 1'b0, "ld_max2");

    // Reset with a load pending must discard it; first edge after release is live.
    LD = 1'b1; LD_G = 4'b1111; EN = 1'b1;
    async_reset("rst_ld");
    step(1'b0, '0, 1'b1, 1'b0, "post_rst");

    // Random mix against the model.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 9) == 0), W'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rnd");

    check("sb.empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter and code width in bits (legal range 2..16).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit, the reset, which is asynchronous and active-high.
REQ-004 The block SHALL have port EN, input, 1 bit, count enable; when low, the count holds.
REQ-005 The block SHALL have port UP, input, 1 bit, count direction: 1 counts up, 0 counts down.
REQ-006 The block SHALL have port LD, input, 1 bit, synchronous load strobe.
REQ-007 The block SHALL have port LD_G, input, WIDTH bits, the Gray-coded load value.
REQ-008 The block SHALL have port G, output, WIDTH bits, the registered Gray-coded count that feeds the downstream Gray-to-binary stage.
REQ-009 The block SHALL have port B, output, WIDTH bits, the registered binary count, always equal to the binary decode of G.
REQ-010 The block SHALL have port TC, output, 1 bit, a registered one-cycle wrap pulse.

Function
REQ-011 The block SHALL hold an internal binary count register and SHALL register G as bin2gray(next count), so that G and B change on the same edge with one cycle of latency from the inputs.
REQ-012 On a clock edge with LD=1, the count SHALL become gray2bin(LD_G), regardless of EN and UP.
REQ-013 On a clock edge with LD=0, EN=1 and UP=1, the count SHALL increment modulo 2^WIDTH.
REQ-014 On a clock edge with LD=0, EN=1 and UP=0, the count SHALL decrement modulo 2^WIDTH.
REQ-015 On a clock edge with LD=0 and EN=0, the count, G, and B SHALL all hold.
REQ-016 Priority SHALL be RST, then LD, then EN.
REQ-017 TC SHALL be 1 for exactly the one cycle following an edge on which a count step wrapped, either up from 2^WIDTH-1 to 0 or down from 0 to 2^WIDTH-1.
REQ-018 TC SHALL be 0 in all other cycles.
REQ-019 A load SHALL never assert TC, including a load to 0 or to the maximum value.
REQ-020 Every count step SHALL change G in exactly one bit, including across the wrap in both directions.
REQ-021 A load MAY change any number of bits of G.
REQ-022 A change of UP between consecutive steps SHALL take effect on the next enabled edge, with no lost or extra step.
REQ-023 The block SHALL contain no combinational path from any input to G, B, or TC.

Reset
REQ-024 While RST=1, G, B, and TC SHALL be 0 immediately, independent of CLK.
REQ-025 Assertion of RST mid-operation SHALL discard any pending load or step.
REQ-026 On the first rising CLK edge after RST falls, the block SHALL operate normally, evaluating LD, EN, and UP on that edge.

Structure
REQ-027 Package gray_pkg SHALL hold the default WIDTH constant and the bin2gray function (b ^ (b >> 1)).
REQ-028 The load-path decode SHALL be a sub-module named gray2bin, the same XOR prefix chain as the downstream converter: msb passes through, and each lower bit is the XOR of the next-higher decoded bit and the Gray bit.
REQ-029 The block SHALL contain no other sub-modules, and SHALL contain a single always block for state with asynchronous RST.

Verification (WIDTH=4)
REQ-030 Reset: assert RST mid-count with CLK stopped -> G=0000, B=0000, TC=0 immediately.
REQ-031 Up run: release RST, EN=1, UP=1 for 16 edges -> G sequence 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; TC=1 only in the cycle after the 1000->0000 edge; each step changes exactly one bit of G.
REQ-032 Down wrap: from 0000, EN=1, UP=0, one edge -> G=1000, B=1111, TC=1 for one cycle; next edge -> G=1001, B=1110, TC=0.
REQ-033 Load then count: LD=1, LD_G=1101 -> B=1001, G=1101, TC=0; next edge with LD=0, EN=1, UP=1 -> B=1010, G=1111.
REQ-034 Priority and hold: LD=1, LD_G=1000 with EN=1, UP=1 -> load wins, B=1111, TC=0. Then EN=0 for 5 edges -> G stays 1000. Then LD=0, EN=1 with UP toggling every edge -> G alternates 0000,1000, with TC pulsing after each wrap edge.
